// File: rtl/prog_clock_divider_if.sv
// Configuration write port of prog_clock_divider: one shadow (div, high) write per accepted beat.
interface prog_clock_divider_if #(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // valid/ready: a beat transfers on the clk_in edge where cfg_valid && cfg_ready are both high;
    // while cfg_valid waits on cfg_ready the master holds cfg_ch/cfg_div/cfg_high stable.
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CH_W-1:0]      cfg_ch;
    logic [CNT_WIDTH-1:0] cfg_div;
    logic [CNT_WIDTH-1:0] cfg_high;

    modport master (output cfg_valid, cfg_ch, cfg_div, cfg_high, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_high, output cfg_ready);
endinterface

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock/tick generator; new settings are shadowed and take effect only at a period boundary.
module prog_clock_divider #(
    parameter int NUM_CH      = 2,
    parameter int CNT_WIDTH   = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                clk_in,
    input  logic                reset,
    prog_clock_divider_if.slave cfg,
    input  logic [NUM_CH-1:0]   en,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   pending
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_WIDTH-1:0] RST_DIV  = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] RST_HIGH = CNT_WIDTH'(DEFAULT_DIV / 2);
    localparam logic [CNT_WIDTH-1:0] MIN_DIV  = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] div_c;
    logic [CNT_WIDTH-1:0] high_c;
    logic                 ready;

    always_comb begin
        div_c  = (cfg.cfg_div < MIN_DIV) ? MIN_DIV : cfg.cfg_div;
        high_c = (cfg.cfg_high >= div_c) ? div_c - ONE : cfg.cfg_high;
    end

    // Channel numbers with no channel behind them never see ready.
    always_comb begin
        ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) ready = ~pending[i];
        end
    end

    assign cfg.cfg_ready = ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] cnt_nxt;
        logic [CNT_WIDTH-1:0] div_act;
        logic [CNT_WIDTH-1:0] high_act;
        logic [CNT_WIDTH-1:0] div_s;
        logic [CNT_WIDTH-1:0] high_s;
        logic                 run;
        logic                 pend_q;
        logic                 clk_q;
        logic                 tick_q;
        logic                 wr;
        logic                 last;

        assign wr      = cfg.cfg_valid && ready && (cfg.cfg_ch == CH_W'(g));
        assign last    = run && (cnt == div_act - ONE);
        assign cnt_nxt = last ? '0 : cnt + ONE;

        // run marks a period in progress; the first enabled edge after idle restarts at cnt=0.
        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                cnt      <= '0;
                div_act  <= RST_DIV;
                high_act <= RST_HIGH;
                div_s    <= RST_DIV;
                high_s   <= RST_HIGH;
                run      <= 1'b0;
                pend_q   <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                if (wr) begin
                    div_s  <= div_c;
                    high_s <= high_c;
                    pend_q <= 1'b1;
                end
                if (!en[g]) begin
                    run    <= 1'b0;
                    cnt    <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (pend_q) begin
                        div_act  <= div_s;
                        high_act <= high_s;
                        pend_q   <= 1'b0;
                    end
                end else if (pend_q && last) begin
                    run      <= 1'b1;
                    cnt      <= '0;
                    div_act  <= div_s;
                    high_act <= high_s;
                    pend_q   <= 1'b0;
                    clk_q    <= (high_s != '0);
                    tick_q   <= 1'b0;
                end else if (!run) begin
                    run    <= 1'b1;
                    cnt    <= '0;
                    clk_q  <= (high_act != '0);
                    tick_q <= 1'b0;
                end else begin
                    cnt    <= cnt_nxt;
                    clk_q  <= (cnt_nxt < high_act);
                    tick_q <= (cnt_nxt == div_act - ONE);
                end
            end
        end

        assign clk_out[g] = clk_q;
        assign tick[g]    = tick_q;
        assign pending[g] = pend_q;
    end
endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: directed table, corner sequences and random traffic against a period-level model.
module tb_prog_clock_divider;
  localparam int CW = 16;

  logic       clk_in = 1'b0;
  logic       reset;
  logic [1:0] en;
  logic [1:0] clk_out, tick, pending;
  logic [2:0] en3, clk_out3, tick3, pending3;
  logic       last_ready;
  int         total = 0;
  int         passed = 0;

  prog_clock_divider_if #(.NUM_CH(2), .CNT_WIDTH(CW)) io ();
  prog_clock_divider_if #(.NUM_CH(3), .CNT_WIDTH(CW)) io3 ();

  prog_clock_divider #(.NUM_CH(2), .CNT_WIDTH(CW), .DEFAULT_DIV(2)) dut (
    .clk_in(clk_in), .reset(reset), .cfg(io), .en(en),
    .clk_out(clk_out), .tick(tick), .pending(pending));

  prog_clock_divider #(.NUM_CH(3), .CNT_WIDTH(CW), .DEFAULT_DIV(2)) dut3 (
    .clk_in(clk_in), .reset(reset), .cfg(io3), .en(en3),
    .clk_out(clk_out3), .tick(tick3), .pending(pending3));

  always #5 clk_in = ~clk_in;

  // Reference model: per channel, the active and shadow settings plus position within the current period.
  int m_div[2], m_high[2], m_sdiv[2], m_shigh[2], m_ph[2];
  bit m_pend[2], m_run[2];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_div[c] = 2; m_high[c] = 1; m_sdiv[c] = 0; m_shigh[c] = 0;
      m_ph[c] = 0; m_pend[c] = 0; m_run[c] = 0;
    end
  endfunction

  function automatic void model_edge(input logic [1:0] e, input bit acc, input int ch, input int d, input int h);
    for (int c = 0; c < 2; c++) begin
      bit at_end;
      at_end = m_run[c] && (m_ph[c] == m_div[c] - 1);
      if (m_pend[c] && (!e[c] || at_end)) begin
        m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c]; m_pend[c] = 0;
      end
      if (!e[c]) begin
        m_run[c] = 0; m_ph[c] = 0;
      end else if (!m_run[c] || at_end) begin
        m_run[c] = 1; m_ph[c] = 0;
      end else begin
        m_ph[c] = m_ph[c] + 1;
      end
    end
    if (acc) begin
      m_sdiv[ch]  = (d < 2) ? 2 : d;
      m_shigh[ch] = (h >= m_sdiv[ch]) ? m_sdiv[ch] - 1 : h;
      m_pend[ch]  = 1;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_outputs();
    logic [1:0] ec, et, ep;
    for (int c = 0; c < 2; c++) begin
      ec[c] = m_run[c] && (m_ph[c] < m_high[c]);
      et[c] = m_run[c] && (m_ph[c] == m_div[c] - 1);
      ep[c] = m_pend[c];
    end
    check("clk_out", 32'(clk_out), 32'(ec));
    check("tick", 32'(tick), 32'(et));
    check("pending", 32'(pending), 32'(ep));
  endtask

  // Called at a falling edge: drive, check ready, clock once, check the registered outputs.
  task automatic step(input logic [1:0] e, input logic v, input logic c, input int d, input int h);
    bit acc;
    en = e; io.cfg_valid = v; io.cfg_ch = c; io.cfg_div = 16'(d); io.cfg_high = 16'(h);
    #1;
    last_ready = io.cfg_ready;
    check("cfg_ready", 32'(io.cfg_ready), 32'(!m_pend[int'(c)]));
    acc = v && !m_pend[int'(c)];
    @(posedge clk_in);
    model_edge(e, acc, int'(c), d, h);
    @(negedge clk_in);
    io.cfg_valid = 1'b0;
    check_outputs();
  endtask

  task automatic wait_apply(input int ch);
    int n = 0;
    while (pending[ch] && n < 40) begin
      step(2'b11, 1'b0, 1'b0, 0, 0);
      n++;
    end
    check("apply_done", 32'(pending[ch]), 32'(0));
  endtask

  task automatic capture(input int ch, input int n, output logic [15:0] pat, output logic [15:0] tk);
    pat = '0; tk = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) step(2'b11, 1'b0, 1'b0, 0, 0);
      pat[i] = clk_out[ch];
      tk[i]  = tick[ch];
    end
  endtask

  typedef struct {
    logic [1:0] en; logic valid; logic ch; int div; int high;
    logic ready; logic [1:0] clk; logic [1:0] tk; logic [1:0] pend;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat, tk;
    int n;
    // en, valid, ch, div, high | ready, clk_out, tick, pending  (bit0 = channel 0)
    vecs[0] = '{2'b11, 1'b0, 1'b0, 0, 0, 1'b1, 2'b11, 2'b00, 2'b00};
    vecs[1] = '{2'b11, 1'b0, 1'b0, 0, 0, 1'b1, 2'b00, 2'b11, 2'b00};
    vecs[2] = '{2'b11, 1'b0, 1'b0, 0, 0, 1'b1, 2'b11, 2'b00, 2'b00};
    vecs[3] = '{2'b11, 1'b1, 1'b0, 5, 2, 1'b1, 2'b00, 2'b11, 2'b01};
    vecs[4] = '{2'b11, 1'b1, 1'b0, 7, 1, 1'b0, 2'b11, 2'b00, 2'b00};
    vecs[5] = '{2'b11, 1'b0, 1'b0, 0, 0, 1'b1, 2'b01, 2'b10, 2'b00};
    vecs[6] = '{2'b11, 1'b0, 1'b0, 0, 0, 1'b1, 2'b10, 2'b00, 2'b00};
    vecs[7] = '{2'b11, 1'b0, 1'b0, 0, 0, 1'b1, 2'b00, 2'b10, 2'b00};
    vecs[8] = '{2'b11, 1'b0, 1'b0, 0, 0, 1'b1, 2'b10, 2'b01, 2'b00};
    vecs[9] = '{2'b11, 1'b0, 1'b0, 0, 0, 1'b1, 2'b01, 2'b10, 2'b00};

    reset = 1'b1; en = 2'b11; en3 = 3'b111;
    io.cfg_valid = 1'b0; io.cfg_ch = 1'b0; io.cfg_div = '0; io.cfg_high = '0;
    io3.cfg_valid = 1'b0; io3.cfg_ch = 2'd0; io3.cfg_div = '0; io3.cfg_high = '0;
    #1;
    check("rst_clk_out", 32'(clk_out), 32'(0));
    check("rst_tick", 32'(tick), 32'(0));
    check("rst_pending", 32'(pending), 32'(0));
    check("rst_cfg_ready", 32'(io.cfg_ready), 32'(1));
    model_reset();
    @(negedge clk_in);
    reset = 1'b0;

    // Default toggling, then a ch0 write mid-period that waits for the boundary.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].en, vecs[i].valid, vecs[i].ch, vecs[i].div, vecs[i].high);
      check($sformatf("tbl%0d_ready", i), 32'(last_ready), 32'(vecs[i].ready));
      check($sformatf("tbl%0d_clk", i), 32'(clk_out), 32'(vecs[i].clk));
      check($sformatf("tbl%0d_tick", i), 32'(tick), 32'(vecs[i].tk));
      check($sformatf("tbl%0d_pend", i), 32'(pending), 32'(vecs[i].pend));
    end

    // ch1 is in its last cycle here: the write lands on the boundary and must wait a full period.
    step(2'b11, 1'b1, 1'b1, 0, 9);
    check("simul_pending", 32'(pending[1]), 32'(1));
    wait_apply(1);
    capture(1, 4, pat, tk);
    check("clamp_div0_pat", 32'(pat), 32'(16'b0101));
    check("clamp_div0_tick", 32'(tk), 32'(16'b1010));
    step(2'b11, 1'b1, 1'b1, 4, 7);
    wait_apply(1);
    capture(1, 8, pat, tk);
    check("clamp_high_pat", 32'(pat), 32'(16'b0111_0111));
    check("clamp_high_tick", 32'(tk), 32'(16'b1000_1000));

    // Disable ch0 mid-period, then restart from cnt=0.
    step(2'b11, 1'b1, 1'b0, 6, 3);
    wait_apply(0);
    step(2'b11, 1'b0, 1'b0, 0, 0);
    step(2'b11, 1'b0, 1'b0, 0, 0);
    step(2'b10, 1'b0, 1'b0, 0, 0);
    check("dis_clk0", 32'(clk_out[0]), 32'(0));
    check("dis_tick0", 32'(tick[0]), 32'(0));
    step(2'b10, 1'b0, 1'b0, 0, 0);
    step(2'b11, 1'b0, 1'b0, 0, 0);
    capture(0, 6, pat, tk);
    check("reen_pat", 32'(pat), 32'(16'b000111));
    check("reen_tick", 32'(tk), 32'(16'b100000));

    // Write while disabled: applies on the following edge.
    step(2'b00, 1'b1, 1'b1, 3, 1);
    check("idle_wr_pending", 32'(pending[1]), 32'(1));
    step(2'b00, 1'b0, 1'b0, 0, 0);
    check("idle_wr_applied", 32'(pending[1]), 32'(0));
    step(2'b11, 1'b0, 1'b0, 0, 0);
    capture(1, 3, pat, tk);
    check("idle_wr_pat", 32'(pat), 32'(16'b001));
    check("idle_wr_tick", 32'(tk), 32'(16'b100));

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic [1:0] e;
      e = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      step(e, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
    end

    // Reset while a write is pending: shadow is dropped, defaults resume.
    en = 2'b11;
    n = 0;
    while (m_pend[0] && n < 40) begin
      step(2'b11, 1'b0, 1'b0, 0, 0);
      n++;
    end
    step(2'b11, 1'b1, 1'b0, 7, 3);
    #2;
    reset = 1'b1;
    #1;
    check("arst_clk_out", 32'(clk_out), 32'(0));
    check("arst_tick", 32'(tick), 32'(0));
    check("arst_pending", 32'(pending), 32'(0));
    check("arst_cfg_ready", 32'(io.cfg_ready), 32'(1));
    model_reset();
    @(negedge clk_in);
    reset = 1'b0;
    step(2'b11, 1'b0, 1'b0, 0, 0);
    capture(0, 4, pat, tk);
    check("post_rst_pat", 32'(pat), 32'(16'b0101));
    check("post_rst_tick", 32'(tk), 32'(16'b1010));
    for (int i = 0; i < 6; i++) step(2'b11, 1'b0, 1'b0, 0, 0);

    // Three-channel instance: a channel number past the last channel is never ready.
    io3.cfg_valid = 1'b1; io3.cfg_ch = 2'd3; io3.cfg_div = 16'd5; io3.cfg_high = 16'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("oor_ready", 32'(io3.cfg_ready), 32'(0));
      step(2'b11, 1'b0, 1'b0, 0, 0);
      check("oor_pending", 32'(pending3), 32'(0));
    end
    io3.cfg_ch = 2'd2;
    #1;
    check("ch2_ready", 32'(io3.cfg_ready), 32'(1));
    io3.cfg_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
